apb_input_capture: RTL and testbench
====================================

Name: apb_input_capture

Overview:
- Parametrised successor to the single-register debug input path: an APB slave observing CHANNELS 8-bit input ports.
- Each port gets a SYNC_STAGES-deep synchroniser, per-channel sticky change flags, and a DEPTH-entry capture FIFO that records every new value of one selected channel.
- Sits behind the I2C-to-APB adapter, beside the debugger, on the 5-bit APB address space.

Parameters:
- CHANNELS, 2, number of 8-bit input channels (1..8).
- SYNC_STAGES, 2, flip-flop stages per input bit (>=1).
- DEPTH, 4, capture FIFO entries (power of two, 2..16).

Ports:
- PCLK  input  1  clock; single clock domain.
- PRESET  input  1  reset; synchronous, active-high.
- PSEL  input  1  APB select.
- PADDR  input  5  APB byte address.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write.
- PWDATA  input  8  write data.
- PRDATA  output  8  read data.
- PREADY  output  1  constant 1 (zero wait states).
- INREG  input  8*CHANNELS  asynchronous inputs; channel c is bits [8c+7:8c].
- IRQ  output  1  level interrupt.

Behaviour:
- Reset (PRESET high at a PCLK edge) clears all of the following to 0: synchroniser flops, previous-value registers, CTRL, CHANGED, FIFO pointers, count and overflow.
- Outputs during and after reset: PRDATA=0 when not selected; IRQ=0; PREADY=1.
- Reset mid-transfer aborts the transfer: no pop, no write side effect.
- Synchroniser: SYNC[c] is INREG[c] after SYNC_STAGES edges. LIVE read shows SYNC[c].
- Change detection: PREV[c] <= SYNC[c] every cycle. A change event is SYNC[c] != PREV[c]; it is evaluated on the same edge that loads PREV.
  - An input step reaches LIVE after SYNC_STAGES edges and sets CHANGED / pushes the FIFO at edge SYNC_STAGES+1.
  - A nonzero input present at reset release therefore produces one change event.
- APB protocol:
  - Setup phase is PSEL & ~PENABLE; access phase is PSEL & PENABLE.
  - Side effects (writes, pop, flush) happen only at the access-phase edge.
  - PRDATA is combinational from PADDR while PSEL=1, and 0 otherwise.
- Register map:
  - 0x00+c  LIVE[c]  RO. For c >= CHANNELS it reads 0.
  - 0x08  CTRL  RW. [0] cap_en, [3:1] cap_sel, [4] irq_en, [7:5] read 0.
  - 0x09  STATUS  RO. [0] empty, [1] full, [2] overflow, [3] 0, [7:4] count (DEPTH=16 full reads 15 with full=1).
  - 0x0A  FIFO  RO. Read returns the head entry and pops it. Read when empty returns 0 with no pointer change.
  - 0x0B  CHANGED  RW1C. Bit c is sticky, set on a change event of channel c. Bits >= CHANNELS read 0.
  - 0x0C  FLUSH  WO. Any write empties the FIFO and clears overflow; reads 0.
  - All other addresses read 0; writes to them are ignored.
- Capture push: happens when cap_en=1, cap_sel < CHANNELS, and channel cap_sel has a change event. The pushed value is SYNC[cap_sel].
- Boundary cases:
  - Full with push and no pop: sample dropped, overflow set (sticky until FLUSH or reset).
  - Full with push and pop in the same cycle: both occur; count stays DEPTH; no overflow.
  - Empty with push and pop in the same cycle: the read returns 0; the push succeeds; count becomes 1.
  - FLUSH and push in the same cycle: flush wins; the FIFO is empty afterwards.
  - Set and W1C clear of the same CHANGED bit in one cycle: set wins.
  - Pointers wrap modulo DEPTH; count is tracked separately, width log2(DEPTH)+1.
- IRQ = irq_en & (~empty | overflow | (CHANGED != 0)), built from registered state only.

Test Plan:
- Reset with INREG=0, then CH0 INREG 0x00 -> 0xA5:
  - LIVE0 reads 0x00 until edge 2 after the change, then 0xA5.
  - CHANGED reads 0x01 from edge 3.
  - Writing 0x01 to 0x0B clears it to 0x00.
- CTRL=0x03 (cap_en, sel=1), drive CH1 = 0x11, 0x22, 0x33 at 4-cycle spacing:
  - STATUS count=3.
  - FIFO reads return 0x11, 0x22, 0x33.
  - Fourth read returns 0x00 and STATUS empty=1.
- DEPTH=4, push 5 changes on the selected channel without reading:
  - STATUS = full|overflow with count 4 (0x46).
  - FIFO reads return the first four values.
  - Writing 0x0C clears STATUS to 0x01.
- FIFO full plus a change event timed to land on the same edge as a FIFO read:
  - Read returns the oldest entry.
  - Count stays 4; overflow stays 0; the new value is the last entry popped.
- Interrupt sequence: irq_en=1 with one capture pending -> IRQ=1. Drain the FIFO and clear CHANGED -> IRQ=0 the cycle after the last access.
- PRESET asserted during the access phase of a FIFO read:
  - No pop occurs; all registers read 0 afterwards.
  - Reads of LIVE at 0x07 with CHANNELS=2, and of 0x1F, return 0.

Source files
------------

// File: rtl/apb_input_capture.sv
// -----------------------------------------------------------------------------
// apb_input_capture
//
// APB slave that observes CHANNELS asynchronous 8-bit input ports. Each port
// passes through a SYNC_STAGES-deep synchroniser. The synchronised value is
// compared against the previous cycle's value to detect changes. Each change
// sets a sticky per-channel CHANGED flag. Changes on one selected channel are
// also recorded in a DEPTH-entry capture FIFO.
//
// Register map (5-bit byte address):
//   0x00+c LIVE[c]  RO   synchronised value of channel c (0 if c >= CHANNELS)
//   0x08   CTRL     RW   [0] cap_en, [3:1] cap_sel, [4] irq_en
//   0x09   STATUS   RO   [0] empty, [1] full, [2] overflow, [7:4] count (sat. 15)
//   0x0A   FIFO     RO   head entry; reading pops it (reads 0 when empty)
//   0x0B   CHANGED  RW1C sticky change flags, one bit per channel
//   0x0C   FLUSH    WO   any write empties the FIFO and clears overflow
//
// Ports:
//   PCLK     clock (single domain)
//   PRESET   synchronous active-high reset
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   APB request
//   PRDATA   read data, combinational from PADDR while PSEL=1, else 0
//   PREADY   always 1 (zero wait states)
//   INREG    asynchronous inputs, channel c on bits [8c+7:8c]
//   IRQ      level interrupt from registered state
// -----------------------------------------------------------------------------
module apb_input_capture #(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic [4:0]            PADDR,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [7:0]            PWDATA,
  output logic [7:0]            PRDATA,
  output logic                  PREADY,
  input  logic [8*CHANNELS-1:0] INREG,
  output logic                  IRQ
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
  localparam logic [3:0]    CH_LIMIT   = 4'(CHANNELS);

  localparam logic [4:0] ADDR_CTRL    = 5'h08;
  localparam logic [4:0] ADDR_STATUS  = 5'h09;
  localparam logic [4:0] ADDR_FIFO    = 5'h0A;
  localparam logic [4:0] ADDR_CHANGED = 5'h0B;
  localparam logic [4:0] ADDR_FLUSH   = 5'h0C;

  // ---------------------------------------------------------------------------
  // Synchroniser and previous-value registers
  // ---------------------------------------------------------------------------
  logic [8*CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [8*CHANNELS-1:0] sync_out;
  logic [8*CHANNELS-1:0] prev_q;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge value of its source; blocking here would collapse
  // the synchroniser chain into a single stage.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= INREG;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_out;
    end
  end

  // Per-channel views padded to 8 channels so that a 3-bit selector or
  // address can index them without range issues; unused slots are zero.
  logic [7:0] sync_ch [8];
  logic [7:0] change_vec;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise a path that skips it infers a latch.
  always_comb begin
    for (int c = 0; c < 8; c++) begin
      sync_ch[c]    = 8'h00;
      change_vec[c] = 1'b0;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      sync_ch[c]    = sync_out[8*c +: 8];
      change_vec[c] = (sync_out[8*c +: 8] != prev_q[8*c +: 8]);
    end
  end

  // ---------------------------------------------------------------------------
  // APB decode
  // ---------------------------------------------------------------------------
  logic access, wr_en, rd_en;

  assign access = PSEL & PENABLE;
  assign wr_en  = access & PWRITE;
  assign rd_en  = access & ~PWRITE;

  // ---------------------------------------------------------------------------
  // CTRL and CHANGED
  // ---------------------------------------------------------------------------
  logic [4:0] ctrl_q, ctrl_d;
  logic [7:0] changed_q, changed_d;
  logic [7:0] w1c_mask;
  logic       cap_en, irq_en;
  logic [2:0] cap_sel;

  assign cap_en  = ctrl_q[0];
  assign cap_sel = ctrl_q[3:1];
  assign irq_en  = ctrl_q[4];

  always_comb begin
    ctrl_d   = ctrl_q;
    w1c_mask = 8'h00;
    if (wr_en && (PADDR == ADDR_CTRL)) ctrl_d = PWDATA[4:0];
    if (wr_en && (PADDR == ADDR_CHANGED)) w1c_mask = PWDATA;
    // A new event is OR-ed in after the clear so a same-cycle set wins.
    changed_d = (changed_q & ~w1c_mask) | change_vec;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q    <= '0;
      changed_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      changed_q <= changed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    fifo_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          fifo_empty, fifo_full;
  logic          push_req, pop_req, flush;
  logic          do_push, do_pop;
  logic [7:0]    push_data;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  assign push_req  = cap_en && ({1'b0, cap_sel} < CH_LIMIT) && change_vec[cap_sel];
  assign push_data = sync_ch[cap_sel];
  assign pop_req   = rd_en && (PADDR == ADDR_FIFO) && !fifo_empty;
  assign flush     = wr_en && (PADDR == ADDR_FLUSH);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    do_push  = 1'b0;
    do_pop   = 1'b0;
    if (flush) begin
      // Flush takes priority over any same-cycle push or pop.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      do_pop  = pop_req;
      // A pop in the same cycle frees the slot a full FIFO needs.
      do_push = push_req && (!fifo_full || pop_req);
      if (push_req && fifo_full && !pop_req) ovf_d = 1'b1;
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so clearing the data would only cost logic.
  always_ff @(posedge PCLK) begin
    if (do_push) fifo_mem_q[wr_ptr_q] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Read mux and outputs
  // ---------------------------------------------------------------------------
  logic [7:0] count_ext;
  logic [3:0] count_nib;
  logic [7:0] status;
  logic [7:0] fifo_head;
  logic [7:0] rdata;

  // A 16-deep full FIFO has count 16, which saturates to 15 in the nibble.
  assign count_ext = 8'(count_q);
  assign count_nib = (count_ext > 8'd15) ? 4'hF : count_ext[3:0];
  assign status    = {count_nib, 1'b0, ovf_q, fifo_full, fifo_empty};
  assign fifo_head = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];

  always_comb begin
    rdata = 8'h00;
    if (PSEL) begin
      if (PADDR[4:3] == 2'b00) begin
        rdata = sync_ch[PADDR[2:0]];
      end else begin
        case (PADDR)
          ADDR_CTRL:    rdata = {3'b000, ctrl_q};
          ADDR_STATUS:  rdata = status;
          ADDR_FIFO:    rdata = fifo_head;
          ADDR_CHANGED: rdata = changed_q;
          default:      rdata = 8'h00;
        endcase
      end
    end
  end

  assign PRDATA = rdata;
  assign PREADY = 1'b1;
  assign IRQ    = irq_en & (!fifo_empty | ovf_q | (changed_q != 8'h00));

endmodule

// File: tb/tb_apb_input_capture.sv
// -----------------------------------------------------------------------------
// tb_apb_input_capture
//
// Directed bench for apb_input_capture with default parameters
// (CHANNELS=2, SYNC_STAGES=2, DEPTH=4). Each scenario task drives APB
// transfers and input steps and compares against hand-computed values.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb_input_capture;

  logic        clk;
  logic        preset;
  logic        psel;
  logic [4:0]  paddr;
  logic        penable;
  logic        pwrite;
  logic [7:0]  pwdata;
  logic [7:0]  prdata;
  logic        pready;
  logic [15:0] inreg;
  logic        irq;

  int checks;
  int errors;

  apb_input_capture #(
    .CHANNELS   (2),
    .SYNC_STAGES(2),
    .DEPTH      (4)
  ) dut (
    .PCLK   (clk),
    .PRESET (preset),
    .PSEL   (psel),
    .PADDR  (paddr),
    .PENABLE(penable),
    .PWRITE (pwrite),
    .PWDATA (pwdata),
    .PRDATA (prdata),
    .PREADY (pready),
    .INREG  (inreg),
    .IRQ    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Setup phase now, access phase after one edge, side effect on the next.
  task automatic apb_write(input logic [4:0] a, input logic [7:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [7:0] d);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #1;
    d = prdata;
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] d;
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 5'h00; pwdata = 8'h00; inreg = 16'h0000;
    wait_cycles(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    checks++;
    if (pready !== 1'b1) begin errors++; $display("FAIL reset_pready: got %b want 1", pready); end
    checks++;
    if (prdata !== 8'h00) begin errors++; $display("FAIL reset_prdata: got %h want 00", prdata); end
    preset = 1'b0;
    tick();
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL reset_status: got %h want 01", d); end
    apb_read(5'h08, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h want 00", d); end
    apb_read(5'h0B, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL reset_changed: got %h want 00", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ctrl_reg();
    logic [7:0] d;
    apb_write(5'h08, 8'hFF);
    apb_read(5'h08, d);
    checks++;
    if (d !== 8'h1F) begin errors++; $display("FAIL ctrl_mask: got %h want 1f", d); end
    // irq_en=1 but nothing pending; sel=7 is out of range so no capture.
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL ctrl_irq_idle: got %b want 0", irq); end
    apb_read(5'h0C, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL flush_reads_0: got %h want 00", d); end
    apb_write(5'h08, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_live_changed();
    logic [7:0] d;
    psel = 1'b1; penable = 1'b0; paddr = 5'h00;
    inreg[7:0] = 8'hA5;
    #1;
    checks++;
    if (prdata !== 8'h00) begin errors++; $display("FAIL live_edge0: got %h want 00", prdata); end
    tick();
    checks++;
    if (prdata !== 8'h00) begin errors++; $display("FAIL live_edge1: got %h want 00", prdata); end
    tick();
    checks++;
    if (prdata !== 8'hA5) begin errors++; $display("FAIL live_edge2: got %h want a5", prdata); end
    paddr = 5'h0B;
    #1;
    checks++;
    if (prdata !== 8'h00) begin errors++; $display("FAIL changed_edge2: got %h want 00", prdata); end
    tick();
    checks++;
    if (prdata !== 8'h01) begin errors++; $display("FAIL changed_edge3: got %h want 01", prdata); end
    psel = 1'b0;
    tick();
    apb_write(5'h0B, 8'h01);
    apb_read(5'h0B, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL changed_w1c: got %h want 00", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_capture();
    logic [7:0] d;
    logic [7:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    apb_write(5'h08, 8'h03);
    for (int i = 0; i < 3; i++) begin
      inreg[15:8] = vals[i];
      wait_cycles(4);
    end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h30) begin errors++; $display("FAIL cap_status: got %h want 30", d); end
    for (int i = 0; i < 3; i++) begin
      apb_read(5'h0A, d);
      checks++;
      if (d !== vals[i]) begin errors++; $display("FAIL cap_pop%0d: got %h want %h", i, d, vals[i]); end
    end
    apb_read(5'h0A, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL cap_pop_empty: got %h want 00", d); end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL cap_status_empty: got %h want 01", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 1; i <= 5; i++) begin
      inreg[15:8] = 8'(i);
      wait_cycles(4);
    end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h46) begin errors++; $display("FAIL ovf_status: got %h want 46", d); end
    for (int i = 1; i <= 4; i++) begin
      apb_read(5'h0A, d);
      checks++;
      if (d !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d: got %h want %h", i, d, 8'(i)); end
    end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h05) begin errors++; $display("FAIL ovf_sticky: got %h want 05", d); end
    apb_write(5'h0C, 8'h00);
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL ovf_flush: got %h want 01", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [7:0] d;
    // Fill to DEPTH.
    for (int i = 1; i <= 4; i++) begin
      inreg[15:8] = 8'h40 + 8'(i);
      wait_cycles(4);
    end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL full_status: got %h want 42", d); end
    // Change event lands on the pop edge (3rd edge after the step).
    inreg[15:8] = 8'h45;
    tick();
    apb_read(5'h0A, d);
    checks++;
    if (d !== 8'h41) begin errors++; $display("FAIL full_pushpop_rd: got %h want 41", d); end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h42) begin errors++; $display("FAIL full_pushpop_status: got %h want 42", d); end
    for (int i = 2; i <= 5; i++) begin
      apb_read(5'h0A, d);
      checks++;
      if (d !== 8'h40 + 8'(i)) begin
        errors++; $display("FAIL full_drain%0d: got %h want %h", i, d, 8'h40 + 8'(i));
      end
    end
    // Empty with simultaneous push and pop.
    inreg[15:8] = 8'h46;
    tick();
    apb_read(5'h0A, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL empty_pushpop_rd: got %h want 00", d); end
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL empty_pushpop_status: got %h want 10", d); end
    apb_read(5'h0A, d);
    checks++;
    if (d !== 8'h46) begin errors++; $display("FAIL empty_pushpop_data: got %h want 46", d); end
    // Flush on the same edge as a push.
    inreg[15:8] = 8'h47;
    tick();
    apb_write(5'h0C, 8'h00);
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL flush_vs_push: got %h want 01", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_irq();
    logic [7:0] d;
    apb_write(5'h0B, 8'hFF);
    apb_write(5'h08, 8'h13);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle: got %b want 0", irq); end
    inreg[15:8] = 8'h55;
    wait_cycles(4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_pending: got %b want 1", irq); end
    apb_read(5'h0A, d);
    checks++;
    if (d !== 8'h55) begin errors++; $display("FAIL irq_pop: got %h want 55", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_changed_only: got %b want 1", irq); end
    apb_write(5'h0B, 8'h02);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared: got %b want 0", irq); end
    // W1C on the same edge as a new event on channel 0: set wins.
    inreg[7:0] = 8'h5A;
    tick();
    apb_write(5'h0B, 8'h01);
    apb_read(5'h0B, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL changed_set_wins: got %h want 01", d); end
    apb_write(5'h0B, 8'h01);
    apb_read(5'h0B, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL changed_reclear: got %h want 00", d); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_transfer();
    logic [7:0] d;
    inreg[15:8] = 8'h66;
    wait_cycles(4);
    inreg = 16'h0000;
    wait_cycles(4);
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL prereset_status: got %h want 20", d); end
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 5'h0A;
    tick();
    penable = 1'b1;
    preset  = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
    #1;
    checks++;
    if (prdata !== 8'h00) begin errors++; $display("FAIL midreset_prdata: got %h want 00", prdata); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", irq); end
    checks++;
    if (pready !== 1'b1) begin errors++; $display("FAIL midreset_pready: got %b want 1", pready); end
    tick();
    preset = 1'b0;
    tick();
    apb_read(5'h09, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL postreset_status: got %h want 01", d); end
    apb_read(5'h08, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL postreset_ctrl: got %h want 00", d); end
    apb_read(5'h0B, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL postreset_changed: got %h want 00", d); end
    apb_read(5'h0A, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL postreset_fifo: got %h want 00", d); end
    apb_read(5'h01, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL postreset_live1: got %h want 00", d); end
    apb_read(5'h07, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL live_unused_ch: got %h want 00", d); end
    apb_read(5'h1F, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL unmapped_1f: got %h want 00", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL postreset_irq: got %b want 0", irq); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ctrl_reg();
    test_live_changed();
    test_capture();
    test_overflow();
    test_back_to_back();
    test_irq();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
